// File: rtl/btn_pkg.sv
// Shared types and constants for the two-button input conditioner.
// Optional build macro BTN_PRESS_COUNT_EN adds a saturating accepted-press counter.
package btn_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } btn_state_t;

   localparam int SYNC_STAGES             = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int PRESS_CNT_W             = 8;

endpackage

// File: rtl/btn_debounce.sv
// Per-button synchroniser, debounce counter and debounced level.
// o_rise is high in the cycle whose closing edge raises the level 0->1, so the
// parent can register its pulse on the same edge the level changes. It is built
// only from registered state; there is no path from i_raw to o_rise.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_in,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   w_s2;
   logic [CNT_W-1:0]       w_cnt_inc;
   logic                   w_flip;

   assign w_s2      = r_sync[SYNC_STAGES-1];
   assign w_cnt_inc = r_cnt + 1'b1;
   // Level changes when this would be the DEBOUNCE_CYCLES-th consecutive mismatch.
   assign w_flip    = (w_s2 != r_level) && (w_cnt_inc == LP_CNT_MAX);

   // Shift the asynchronous input through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      end
   end

   // Count consecutive mismatches; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (w_s2 == r_level) begin
         r_cnt   <= '0;
      end else if (w_flip) begin
         r_level <= w_s2;
         r_cnt   <= '0;
      end else begin
         r_cnt   <= w_cnt_inc;
      end
   end

   assign o_level = r_level;
   assign o_rise  = w_flip && w_s2;

endmodule

// File: rtl/button_conditioner.sv
// Two-button input stage for the lock FSM: debounce, single-press acceptance,
// simultaneous-press rejection and lockout until both buttons are released.
// Optional build macro BTN_PRESS_COUNT_EN adds press_count (saturating, 8 bits).
module button_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_in,
   input  logic b0_raw,
   input  logic b1_raw,
   output logic b0_pulse,
   output logic b1_pulse,
   output logic both_err,
   output logic b0_level,
   output logic b1_level,
   output logic busy
`ifdef BTN_PRESS_COUNT_EN
   ,
   output logic [PRESS_CNT_W-1:0] press_count
`endif
);

   logic       w_level0, w_level1;
   logic       w_rise0, w_rise1;
   logic       w_both_low;
   logic       w_take;
   btn_state_t r_state;
   logic       r_b0_pulse, r_b1_pulse, r_both_err, r_busy;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
      .clk      (clk),
      .reset_in (reset_in),
      .i_raw    (b0_raw),
      .o_level  (w_level0),
      .o_rise   (w_rise0)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
      .clk      (clk),
      .reset_in (reset_in),
      .i_raw    (b1_raw),
      .o_level  (w_level1),
      .o_rise   (w_rise1)
   );

   assign w_both_low = !w_level0 && !w_level1;
   // HELD with both buttons released behaves like IDLE, so a rise landing on the
   // release-to-IDLE edge is still accepted instead of leaving a high level behind.
   assign w_take     = (r_state == IDLE) || w_both_low;

   // Acceptance FSM with registered pulse, error and busy outputs.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_state    <= IDLE;
         r_b0_pulse <= 1'b0;
         r_b1_pulse <= 1'b0;
         r_both_err <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_b0_pulse <= 1'b0;
         r_b1_pulse <= 1'b0;
         r_both_err <= 1'b0;
         if (w_take) begin
            if (w_rise0 && w_rise1) begin
               r_both_err <= 1'b1;
               r_state    <= HELD;
               r_busy     <= 1'b1;
            end else if (w_rise0) begin
               r_b0_pulse <= 1'b1;
               r_state    <= HELD;
               r_busy     <= 1'b1;
            end else if (w_rise1) begin
               r_b1_pulse <= 1'b1;
               r_state    <= HELD;
               r_busy     <= 1'b1;
            end else begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
            end
         end
      end
   end

   assign b0_pulse = r_b0_pulse;
   assign b1_pulse = r_b1_pulse;
   assign both_err = r_both_err;
   assign busy     = r_busy;
   assign b0_level = w_level0;
   assign b1_level = w_level1;

`ifdef BTN_PRESS_COUNT_EN
   logic [PRESS_CNT_W-1:0] r_press_cnt;

   // Count accepted single presses, saturating at all-ones; both_err is excluded.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_press_cnt <= '0;
      end else if (w_take && (w_rise0 ^ w_rise1) && (r_press_cnt != '1)) begin
         r_press_cnt <= r_press_cnt + 1'b1;
      end
   end

   assign press_count = r_press_cnt;
`endif

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input stage for the two-button lock FSM. It synchronises, debounces and edge-detects the raw b0/b1 pushbuttons. It produces the single-cycle press pulses that drive the lock FSM's b0_in/b1_in ports. Simultaneous presses are rejected, and new presses are locked out until both buttons are released, so the lock only ever sees one clean press per physical actuation.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced level before that level changes (>=1)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge
reset_in  input  1  synchronous, active-high reset
b0_raw  input  1  raw button 0, asynchronous, may bounce
b1_raw  input  1  raw button 1, asynchronous, may bounce
b0_pulse  output  1  one-cycle accepted press of button 0 (to lock b0_in)
b1_pulse  output  1  one-cycle accepted press of button 1 (to lock b1_in)
both_err  output  1  one-cycle flag: both buttons became pressed in the same cycle
b0_level  output  1  debounced level of button 0
b1_level  output  1  debounced level of button 1
busy  output  1  high while in HELD (presses locked out)

Behaviour:
- Reset (reset_in high at an edge): synchroniser flops, debounced levels, counters and all outputs go to 0; FSM goes to IDLE. Reset has priority over everything, including mid-debounce and mid-pulse.
- Synchroniser: 2 flops per button (s1, s2), both reset to 0.
- Debounce (per button):
  - If s2 != level, the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, level <= s2 and the counter clears.
  - If s2 == level, the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Rise event: the level changes 0->1 at this edge.
- Latency: raw goes high before edge k, so s1=1 after edge k and the level rises at edge k+1+DEBOUNCE_CYCLES. The pulse is registered at that same edge and stays high for exactly one cycle.
- FSM states:
  - IDLE:
    - Exactly one rise -> corresponding pulse, go HELD.
    - Both rise in the same cycle -> both_err pulse, no bN_pulse, go HELD.
    - No rise -> stay IDLE.
  - HELD: no pulses are produced, and rises are ignored. When b0_level==0 and b1_level==0 -> IDLE (one cycle after both levels are low).
- busy = (state==HELD), registered.
- A rise in the same cycle the FSM returns to IDLE is not lost. Levels are evaluated from IDLE on the next cycle only if a new rise occurs; a level already high at IDLE entry cannot occur by construction.
- A button held through reset: level is 0 after reset, then rises after debounce and yields exactly one pulse. This is accepted behaviour.
- Outputs are all registered; no combinational path from raw inputs to outputs.

Optional Feature:
BTN_PRESS_COUNT_EN:
- Defined: adds an output press_count [7:0], an 8-bit saturating count of accepted bN_pulse events. It is reset to 0, holds at 255, and both_err does not count.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package btn_pkg holds:
  - state enum btn_state_t {IDLE, HELD};
  - SYNC_STAGES=2;
  - default DEBOUNCE_CYCLES;
  - PRESS_CNT_W=8.
- Sub-module btn_debounce (synchroniser + counter + level + rise output, parameter DEBOUNCE_CYCLES) is instantiated twice.
- The FSM and pulse/err registers live in the top.

Test Plan:
1. reset_in high 2 cycles with raw inputs toggling -> all outputs 0 through reset and the first cycle after it.
2. b1_raw high from before edge k for 10 cycles (DEBOUNCE_CYCLES=4):
   - b1_level rises at edge k+5;
   - b1_pulse is high only between edges k+5 and k+6;
   - b0_pulse stays 0 and busy stays 1 until release.
3. b0_raw high 3 cycles then low -> b0_level, b0_pulse and busy remain 0 throughout.
4. b0_raw and b1_raw rise together, held 8 cycles -> both_err is high for one cycle at edge k+5; b0_pulse=b1_pulse=0; busy=1.
5. Lockout and recovery:
   - b0 pressed and held, then b1 pressed while b0 held -> one b0_pulse, no b1_pulse.
   - Both released for >=6 cycles -> busy=0.
   - Next b1 press -> one b1_pulse.
6. Reset mid-debounce: b0_raw high, reset_in pulsed 1 cycle after 2 cycles of debounce, b0_raw stays high -> exactly one b0_pulse, 5 edges after the first post-reset edge. With BTN_PRESS_COUNT_EN, press_count=1.
